sap1_fetch_unit: RTL and testbench
==================================

# sap1_fetch_unit

Program-counter, memory-address and instruction-register stage of the SAP-1 core, sitting directly upstream of the microcode controller. It generates instruction addresses, captures fetched instruction bytes from the shared 8-bit bus, presents the 4-bit opcode to the controller, drives the operand nibble back onto the bus on request, and latches the halt condition.

## Interface
Parameters:
- `HLT_OPCODE`, 4'hF: opcode that sets the halt latch.
- `RESET_PC`, 4'h0: PC value loaded at reset.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `bus_in`  in  8  shared data bus value.
- `pc_inc`  in  1  increment PC.
- `pc_en`  in  1  drive PC onto bus.
- `mar_ld`  in  1  load MAR from `bus_in[3:0]`.
- `ir_ld`  in  1  load IR from `bus_in[7:0]`.
- `ir_en`  in  1  drive IR operand onto bus.
- `pc_ld`  in  1  load PC from `bus_in[3:0]` (only with `SAP1_JUMP_EN`).
- `bus_out`  out  8  value driven toward bus.
- `bus_oe`  out  1  bus drive enable.
- `bus_conflict`  out  1  sticky flag: `pc_en` and `ir_en` were high in the same cycle.
- `mem_addr`  out  4  MAR contents, to RAM address.
- `opcode`  out  4  `ir[7:4]`, to controller.
- `operand`  out  4  `ir[3:0]`.
- `pc`  out  4  current PC.
- `halted`  out  1  halt latch.

## Operation
- Registers: `pc[3:0]`, `mar[3:0]`, `ir[7:0]`, `halted`, `bus_conflict`.
- Reset (`rst_n` low, asynchronous): pc=`RESET_PC`, mar=0, ir=8'h00 (opcode 0), halted=0, bus_conflict=0.
- PC: `pc_inc` adds 1 modulo 16 (4'hF -> 4'h0, no carry out).
- MAR: `mar_ld` captures `bus_in[3:0]`; `bus_in[7:4]` ignored.
- IR: `ir_ld` captures full `bus_in`.
- Halt: on an edge with `ir_ld`=1 and `bus_in[7:4]==HLT_OPCODE`, IR loads and `halted` sets on the same edge. Once set, `pc_inc`, `pc_ld`, `mar_ld`, `ir_ld` are ignored; only reset clears it. Bus drive (`pc_en`, `ir_en`) still works while halted.
- Bus drive (combinational): `bus_oe` = `pc_en | ir_en`. `pc_en` -> `bus_out`={4'h0,pc}; else `ir_en` -> {4'h0,ir[3:0]}; else 8'h00. `pc_en` wins when both are high, and `bus_conflict` sets on that edge (sticky until reset).
- Same-cycle `mar_ld` with `pc_en`: MAR takes the current (pre-increment) PC even if `pc_inc` is also high.
- Independent strobes in one cycle all take effect on the same edge.

## Timing
- All register outputs change only on the rising `clk` edge after the strobe; latency 1 cycle.
- `opcode`/`operand`/`mem_addr`/`pc` valid from the edge and stable for the whole following cycle, so the controller indexes microcode with the new opcode in the next step.
- `bus_out`/`bus_oe` follow `pc_en`/`ir_en` combinationally, zero cycles.
- Reset deassertion is synchronous to use: the first strobe is honoured on the first rising edge with `rst_n` high.
- Reset mid-instruction: all state clears immediately, regardless of `clk`.

## Configuration
- `SAP1_JUMP_EN` defined: `pc_ld` loads `pc` from `bus_in[3:0]`; with `pc_inc` in the same cycle, `pc_ld` wins (no increment). Blocked while halted.
- Not defined: `pc_ld` is ignored and unconnected internally; PC changes only by increment or reset.

## Test plan
- Reset then four `pc_inc` pulses -> pc 0,1,2,3,4; `bus_oe`=0, `bus_conflict`=0.
- Fetch: `pc_en`+`mar_ld` with pc=3 -> mem_addr=3; then `ir_ld` with bus_in=8'h2A -> opcode=4'h2, operand=4'hA; `ir_en` -> bus_out=8'h0A, `bus_oe`=1.
- Sixteen `pc_inc` from pc=0 -> returns to 0 (wrap 4'hF->4'h0).
- `ir_ld` with bus_in=8'hF0 -> halted=1 same edge; subsequent `pc_inc`/`ir_ld` with 8'h15 -> pc and ir unchanged.
- `pc_en` and `ir_en` together with pc=5, ir=8'h37 -> bus_out=8'h05, `bus_conflict` set and held until `rst_n` pulse.
- With `SAP1_JUMP_EN`: `pc_ld`+`pc_inc`, bus_in=8'h0C, pc=2 -> pc=4'hC; without it -> pc=3.

Source files
------------

// File: rtl/sap1_fetch_unit.sv
// rtl/sap1_fetch_unit.sv - SAP-1 PC/MAR/IR fetch stage with halt latch and bus drive.
// Optional jump support (pc_ld) is enabled by defining SAP1_JUMP_EN.
module sap1_fetch_unit #(
  parameter logic [3:0] HLT_OPCODE = 4'hF,
  parameter logic [3:0] RESET_PC   = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_in,
  input  logic       pc_inc,
  input  logic       pc_en,
  input  logic       mar_ld,
  input  logic       ir_ld,
  input  logic       ir_en,
  input  logic       pc_ld,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       bus_conflict,
  output logic [3:0] mem_addr,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  output logic [3:0] pc,
  output logic       halted
);

  logic [3:0] pc_q;
  logic [3:0] mar_q;
  logic [7:0] ir_q;
  logic       halted_q;
  logic       conflict_q;
  logic       pc_load;

`ifdef SAP1_JUMP_EN
  assign pc_load = pc_ld;
`else
  logic unused_pc_ld;
  assign unused_pc_ld = pc_ld;
  assign pc_load      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      mar_q      <= 4'h0;
      ir_q       <= 8'h00;
      halted_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      // Bus contention is recorded even while halted since bus drive stays live.
      if (pc_en && ir_en) begin
        conflict_q <= 1'b1;
      end
      if (!halted_q) begin
        if (pc_load) begin
          pc_q <= bus_in[3:0];
        end else if (pc_inc) begin
          pc_q <= pc_q + 4'd1;
        end
        if (mar_ld) begin
          mar_q <= bus_in[3:0];
        end
        if (ir_ld) begin
          ir_q <= bus_in;
          if (bus_in[7:4] == HLT_OPCODE) begin
            halted_q <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus_out = 8'h00;
    if (pc_en) begin
      bus_out = {4'h0, pc_q};
    end else if (ir_en) begin
      bus_out = {4'h0, ir_q[3:0]};
    end
  end

  assign bus_oe       = pc_en | ir_en;
  assign bus_conflict = conflict_q;
  assign mem_addr     = mar_q;
  assign opcode       = ir_q[7:4];
  assign operand      = ir_q[3:0];
  assign pc           = pc_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// tb/tb_sap1_fetch_unit.sv - randomized self-checking bench for sap1_fetch_unit.
// Directed spec scenarios plus a random run against a behavioural model; honours SAP1_JUMP_EN.
module tb_sap1_fetch_unit;

`ifdef SAP1_JUMP_EN
  localparam bit JUMP = 1'b1;
`else
  localparam bit JUMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic       pc_inc = 1'b0, pc_en = 1'b0, mar_ld = 1'b0, ir_ld = 1'b0, ir_en = 1'b0, pc_ld = 1'b0;
  logic [7:0] bus_out;
  logic       bus_oe, bus_conflict, halted;
  logic [3:0] mem_addr, opcode, operand, pc;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir;
  bit         m_halt, m_conf;

  sap1_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .pc_inc(pc_inc), .pc_en(pc_en),
    .mar_ld(mar_ld), .ir_ld(ir_ld), .ir_en(ir_en), .pc_ld(pc_ld), .bus_out(bus_out),
    .bus_oe(bus_oe), .bus_conflict(bus_conflict), .mem_addr(mem_addr), .opcode(opcode),
    .operand(operand), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_bus(bit pe, bit ie);
    if (pe) return {4'h0, m_pc};
    if (ie) return {4'h0, m_ir[3:0]};
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_pc = 4'h0; m_mar = 4'h0; m_ir = 8'h00; m_halt = 1'b0; m_conf = 1'b0;
  endtask

  // Rules of one clock edge, applied to the values present on the inputs before it.
  task automatic model_edge();
    if (pc_en && ir_en) m_conf = 1'b1;
    if (!m_halt) begin
      if (JUMP && pc_ld) m_pc = bus_in[3:0];
      else if (pc_inc) m_pc = 4'((m_pc + 1) % 16);
      if (mar_ld) m_mar = bus_in[3:0];
      if (ir_ld) begin
        m_ir = bus_in;
        if (bus_in[7:4] == 4'hF) m_halt = 1'b1;
      end
    end
  endtask

  task automatic clear_strobes();
    pc_inc = 0; pc_en = 0; mar_ld = 0; ir_ld = 0; ir_en = 0; pc_ld = 0;
  endtask

  // Drive one cycle of strobes; the shared bus carries whatever this stage drives.
  task automatic step(input bit inc, pe, ml, il, ie, pl, input logic [7:0] bv);
    pc_inc = inc; pc_en = pe; mar_ld = ml; ir_ld = il; ir_en = ie; pc_ld = pl;
    bus_in = (pe || ie) ? exp_bus(pe, ie) : bv;
    @(posedge clk);
    model_edge();
    #1;
    clear_strobes();
  endtask

  task automatic do_reset();
    clear_strobes();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step(1, 0, 1, 1, 0, 0, 8'h59);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pc, mem_addr, opcode, operand, halted, bus_conflict, bus_oe} !== {4'h0, 4'h0, 8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_async: got pc=%h mar=%h ir=%h%h halt=%b conf=%b oe=%b required all zero",
               pc, mem_addr, opcode, operand, halted, bus_conflict, bus_oe);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_pc_count();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 0, 8'h00);
      vectors++;
      if (pc !== 4'(i + 1) || bus_oe !== 1'b0 || bus_conflict !== 1'b0) begin
        miscompares++;
        $display("FAIL pc_count[%0d]: got pc=%h oe=%b conf=%b required pc=%h oe=0 conf=0",
                 i, pc, bus_oe, bus_conflict, 4'(i + 1));
      end
    end
  endtask

  task automatic test_fetch();
    do_reset();
    repeat (3) step(1, 0, 0, 0, 0, 0, 8'h00);
    pc_en = 1'b1;
    #1;
    vectors++;
    if (bus_out !== 8'h03 || bus_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_pc_drive: got bus_out=%h oe=%b required 03/1", bus_out, bus_oe);
    end
    step(1, 1, 1, 0, 0, 0, 8'h00);
    vectors++;
    if (mem_addr !== 4'h3 || pc !== 4'h4) begin
      miscompares++;
      $display("FAIL fetch_mar: got mar=%h pc=%h required mar=3 pc=4", mem_addr, pc);
    end
    step(0, 0, 0, 1, 0, 0, 8'h2A);
    vectors++;
    if (opcode !== 4'h2 || operand !== 4'hA || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_ir: got op=%h opnd=%h halt=%b required 2/A/0", opcode, operand, halted);
    end
    ir_en = 1'b1;
    #1;
    vectors++;
    if (bus_out !== 8'h0A || bus_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_ir_drive: got bus_out=%h oe=%b required 0A/1", bus_out, bus_oe);
    end
    ir_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (15) step(1, 0, 0, 0, 0, 0, 8'h00);
    vectors++;
    if (pc !== 4'hF) begin
      miscompares++;
      $display("FAIL wrap_15: got pc=%h required F", pc);
    end
    step(1, 0, 0, 0, 0, 0, 8'h00);
    vectors++;
    if (pc !== 4'h0) begin
      miscompares++;
      $display("FAIL wrap_16: got pc=%h required 0", pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    step(1, 0, 1, 0, 0, 0, 8'h07);
    step(0, 0, 0, 1, 0, 0, 8'hF0);
    vectors++;
    if (halted !== 1'b1 || opcode !== 4'hF || operand !== 4'h0) begin
      miscompares++;
      $display("FAIL halt_set: got halt=%b op=%h opnd=%h required 1/F/0", halted, opcode, operand);
    end
    step(1, 0, 1, 1, 0, 1, 8'h15);
    vectors++;
    if (pc !== 4'h1 || mem_addr !== 4'h7 || {opcode, operand} !== 8'hF0 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_freeze: got pc=%h mar=%h ir=%h%h halt=%b required 1/7/F0/1",
               pc, mem_addr, opcode, operand, halted);
    end
    pc_en = 1'b1;
    #1;
    vectors++;
    if (bus_out !== 8'h01 || bus_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_drive: got bus_out=%h oe=%b required 01/1", bus_out, bus_oe);
    end
    pc_en = 1'b0;
  endtask

  task automatic test_conflict();
    do_reset();
    repeat (5) step(1, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 0, 8'h37);
    pc_en = 1'b1; ir_en = 1'b1;
    #1;
    vectors++;
    if (bus_out !== 8'h05 || bus_oe !== 1'b1 || bus_conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_drive: got bus_out=%h oe=%b conf=%b required 05/1/0", bus_out, bus_oe, bus_conflict);
    end
    step(0, 1, 0, 0, 1, 0, 8'h00);
    repeat (3) step(0, 0, 0, 0, 0, 0, 8'h00);
    vectors++;
    if (bus_conflict !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_sticky: got conf=%b required 1", bus_conflict);
    end
    do_reset();
    vectors++;
    if (bus_conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_clear: got conf=%b required 0", bus_conflict);
    end
  endtask

  task automatic test_jump();
    do_reset();
    repeat (2) step(1, 0, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 1, 8'h0C);
    vectors++;
    if (pc !== (JUMP ? 4'hC : 4'h3)) begin
      miscompares++;
      $display("FAIL jump: got pc=%h required %h", pc, JUMP ? 4'hC : 4'h3);
    end
  endtask

  task automatic test_random();
    logic [7:0] bv, eb;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (pc !== m_pc || halted !== 1'b0 || bus_conflict !== 1'b0 || {opcode, operand} !== 8'h00) begin
          miscompares++;
          $display("FAIL rand_reset[%0d]: got pc=%h halt=%b conf=%b ir=%h%h required cleared",
                   n, pc, halted, bus_conflict, opcode, operand);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      pc_inc = 1'($urandom); pc_en = ($urandom_range(0, 3) == 0); mar_ld = 1'($urandom);
      ir_ld = 1'($urandom); ir_en = ($urandom_range(0, 3) == 0); pc_ld = ($urandom_range(0, 3) == 0);
      bv = 8'($urandom);
      if (bv[7:4] == 4'hF && $urandom_range(0, 3) != 0) bv[7:4] = 4'h1;
      eb = exp_bus(pc_en, ir_en);
      bus_in = (pc_en || ir_en) ? eb : bv;
      #1;
      vectors++;
      if (bus_out !== eb || bus_oe !== (pc_en | ir_en)) begin
        miscompares++;
        $display("FAIL rand_bus[%0d]: got bus_out=%h oe=%b required %h/%b", n, bus_out, bus_oe, eb, pc_en | ir_en);
      end
      @(posedge clk);
      model_edge();
      #1;
      clear_strobes();
      vectors++;
      if (pc !== m_pc || mem_addr !== m_mar || {opcode, operand} !== m_ir ||
          halted !== m_halt || bus_conflict !== m_conf) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: got pc=%h mar=%h ir=%h%h halt=%b conf=%b required %h/%h/%h/%b/%b",
                 n, pc, mem_addr, opcode, operand, halted, bus_conflict, m_pc, m_mar, m_ir, m_halt, m_conf);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pc_count();
    test_fetch();
    test_wrap();
    test_halt();
    test_conflict();
    test_jump();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
